// File: rtl/fetch_buffer_pkg.sv
// Shared types and constants for the instruction fetch path.
//   INSTR_W      : width of one instruction word
//   fetch_resp_t : one queued fetch response (error flag + instruction word)
//   select_word  : picks the 32-bit half of a 64-bit SRAM doubleword
package fetch_buffer_pkg;

    localparam int INSTR_W = 32;

    typedef struct packed {
        logic               err;
        logic [INSTR_W-1:0] instr;
    } fetch_resp_t;

    // upper = byte-address bit 2, i.e. the second word of the doubleword.
    function automatic logic [INSTR_W-1:0] select_word(input logic [63:0] dword,
                                                       input logic        upper);
        return upper ? dword[63:32] : dword[31:0];
    endfunction

endpackage

// File: rtl/fetch_buffer_sync_fifo.sv
// Generic synchronous show-ahead FIFO.
//   clk, rstn        : clock, synchronous active-low reset
//   clear            : synchronous flush of pointers and count
//   push, push_data  : write side
//   pop, pop_data    : read side; pop_data shows the head, 0 when empty
//   count            : number of stored entries (0..DEPTH)
//   full, empty      : status flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;

    // A push into a full FIFO is accepted only when the head leaves in the
    // same cycle; the slot being written is then the one being vacated.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    assign pop_data = empty ? '0 : mem_reg[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        case ({wr_en, rd_en})
            2'b10:   count_next = count_reg + (PTR_W+1)'(1);
            2'b01:   count_next = count_reg - (PTR_W+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage has no reset; entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Decouples the core fetch handshake from a 1-cycle-latency 64-bit SRAM.
//   clk, rstn                    : clock, synchronous active-low reset
//   req_valid_i/req_ready_o      : fetch address handshake
//   req_addr_i                   : fetch byte address (bits [1:0] ignored)
//   resp_valid_o/resp_ready_i    : instruction handshake
//   resp_data_o, resp_err_o      : instruction word, out-of-range flag
//   flush_i                      : drop every queued and in-flight fetch
//   mem_en_o, mem_addr_o         : SRAM read request (doubleword index)
//   mem_rdata_i                  : SRAM data, one cycle after mem_en_o
// Accept-to-response latency is exactly two cycles (no bypass).
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int ADDR_WIDTH = 20,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [XLEN-1:0]       req_addr_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [INSTR_W-1:0]    resp_data_o,
    output logic                  resp_err_o,
    input  logic                  flush_i,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [63:0]           mem_rdata_i
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W+1)'(DEPTH);

    logic             inflight_q;
    logic             bo_q;
    logic             err_q;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   occupancy;
    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;
    logic             push;
    logic             pop;
    fetch_resp_t      push_entry;
    fetch_resp_t      head_entry;
    logic             unused_addr_bits;

    // Word alignment is assumed; the two lowest address bits carry nothing.
    assign unused_addr_bits = &{1'b0, req_addr_i[1:0]};

    // Every accepted fetch holds a credit until it is popped, so a push can
    // never find the FIFO full.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign pop       = resp_valid_o && resp_ready_i;

    always_comb begin
        req_ready_o = 1'b0;
        if (rstn && !flush_i) begin
            req_ready_o = (occupancy < DEPTH_OCC) || ((occupancy == DEPTH_OCC) && pop);
        end
    end

    assign accept     = req_valid_i && req_ready_o;
    assign mem_en_o   = accept;
    assign mem_addr_o = req_addr_i[ADDR_WIDTH+2:3];

    // In-flight tracking for the single outstanding SRAM read.
    always_ff @(posedge clk) begin
        if (!rstn || flush_i) begin
            inflight_q <= 1'b0;
            bo_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= accept;
            if (accept) begin
                bo_q  <= req_addr_i[2];
                err_q <= (req_addr_i[XLEN-1:ADDR_WIDTH+3] != '0);
            end
        end
    end

    // Out-of-range reads still touch the SRAM; their data is replaced by 0.
    assign push             = inflight_q;
    assign push_entry.err   = err_q;
    assign push_entry.instr = err_q ? '0 : select_word(mem_rdata_i, bo_q);

    // flush_i clears the FIFO at the end of the flush cycle, which also
    // discards a response landing in that same cycle.
    sync_fifo #(
        .WIDTH ($bits(fetch_resp_t)),
        .DEPTH (DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (flush_i),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign resp_valid_o = !fifo_empty;
    assign resp_data_o  = head_entry.instr;
    assign resp_err_o   = head_entry.err;

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rstn)
        !(push && fifo_full));

endmodule
